// File: rtl/idli_fetch_m.sv
// Instruction fetch: sequential SQI quad reads, four nibbles per 16b word, PC tracking and redirects.
// Latency: word valid at ctr==3 of the fourth period after a (re)start; nibble 3 bypasses straight from the pins.
// Backpressure: none; the 2b counter free-runs and decode must take each word in its ctr==3 cycle.
module idli_fetch_m #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  SQI_CMD  = 8'h03
) (
    input  logic        i_fe_gck,
    input  logic        i_fe_rst_n,
    output logic [1:0]  o_fe_ctr,
    output logic [15:0] o_fe_enc,
    output logic        o_fe_enc_vld,
    output logic [15:0] o_fe_pc,
    input  logic        i_fe_imm,
    input  logic        i_fe_redir,
    input  logic [15:0] i_fe_redir_pc,
    output logic        o_fe_sqi_cs_n,
    output logic        o_fe_sqi_oe,
    output logic [3:0]  o_fe_sqi_out,
    input  logic [3:0]  i_fe_sqi_in
);

    // ADDR spans six cycles, split as ADDR0 (ctr 0-3) and ADDR1 (ctr 0,1).
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR0,
        ST_ADDR1,
        ST_DUMMY,
        ST_DATA
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ctr;
    logic [1:0]  ctr_nxt;
    logic [15:0] pc;
    logic [15:0] pc_nxt;
    logic [11:0] nib_buf;
    logic [23:0] byte_addr;
    logic        cs_n_nxt;
    logic        oe_nxt;
    logic [3:0]  out_nxt;
    logic        cs_n_q;
    logic        oe_q;
    logic [3:0]  out_q;
    logic        last_nib;

    assign last_nib  = (ctr == 2'd3);
    assign ctr_nxt   = ctr + 2'd1;
    // pc only moves at ctr==3, so during setup it is the address being requested.
    assign byte_addr = {7'b0, pc_nxt, 1'b0};

    // Next state and PC: redirect wins over everything, DATA advances or wraps via IDLE.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (last_nib && i_fe_redir) begin
            state_nxt = ST_IDLE;
            pc_nxt    = i_fe_redir_pc;
        end else begin
            case (state)
                ST_IDLE:  if (ctr == 2'd1) state_nxt = ST_CMD;
                ST_CMD:   if (last_nib)    state_nxt = ST_ADDR0;
                ST_ADDR0: if (last_nib)    state_nxt = ST_ADDR1;
                ST_ADDR1: if (ctr == 2'd1) state_nxt = ST_DUMMY;
                ST_DUMMY: if (last_nib)    state_nxt = ST_DATA;
                ST_DATA: begin
                    if (last_nib) begin
                        if (pc == 16'hFFFF) begin
                            state_nxt = ST_IDLE;
                            pc_nxt    = 16'h0000;
                        end else begin
                            pc_nxt = pc + 16'd1;
                        end
                    end
                end
                default:                   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pin values for the coming cycle, so the pins themselves can be flops.
    always_comb begin
        cs_n_nxt = 1'b0;
        oe_nxt   = 1'b0;
        out_nxt  = 4'h0;
        case (state_nxt)
            ST_IDLE: cs_n_nxt = 1'b1;
            ST_CMD: begin
                oe_nxt  = 1'b1;
                out_nxt = (ctr_nxt == 2'd2) ? SQI_CMD[7:4] : SQI_CMD[3:0];
            end
            ST_ADDR0: begin
                oe_nxt = 1'b1;
                case (ctr_nxt)
                    2'd0:    out_nxt = byte_addr[23:20];
                    2'd1:    out_nxt = byte_addr[19:16];
                    2'd2:    out_nxt = byte_addr[15:12];
                    default: out_nxt = byte_addr[11:8];
                endcase
            end
            ST_ADDR1: begin
                oe_nxt  = 1'b1;
                out_nxt = (ctr_nxt == 2'd0) ? byte_addr[7:4] : byte_addr[3:0];
            end
            default: begin
                cs_n_nxt = 1'b0;
            end
        endcase
    end

    // Sequencer: counter, state, PC and registered SRAM pins; reset drops cs_n at once.
    always_ff @(posedge i_fe_gck or negedge i_fe_rst_n) begin
        if (!i_fe_rst_n) begin
            ctr    <= 2'd0;
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            cs_n_q <= 1'b1;
            oe_q   <= 1'b0;
            out_q  <= 4'h0;
        end else begin
            ctr    <= ctr_nxt;
            state  <= state_nxt;
            pc     <= pc_nxt;
            cs_n_q <= cs_n_nxt;
            oe_q   <= oe_nxt;
            out_q  <= out_nxt;
        end
    end

    // Capture the first three nibbles of each word; the fourth is bypassed.
    always_ff @(posedge i_fe_gck or negedge i_fe_rst_n) begin
        if (!i_fe_rst_n) begin
            nib_buf <= 12'h000;
        end else if (state == ST_DATA) begin
            case (ctr)
                2'd0:    nib_buf[3:0]  <= i_fe_sqi_in;
                2'd1:    nib_buf[7:4]  <= i_fe_sqi_in;
                2'd2:    nib_buf[11:8] <= i_fe_sqi_in;
                default: nib_buf       <= nib_buf;
            endcase
        end
    end

    assign o_fe_ctr      = ctr;
    assign o_fe_pc       = pc;
    assign o_fe_enc      = {i_fe_sqi_in, nib_buf};
    assign o_fe_enc_vld  = (state == ST_DATA) && last_nib && !i_fe_imm && !i_fe_redir;
    assign o_fe_sqi_cs_n = cs_n_q;
    assign o_fe_sqi_oe   = oe_q;
    assign o_fe_sqi_out  = out_q;

endmodule

// File: tb/tb_idli_fetch_m.sv
// Directed bench for idli_fetch_m: pin traces, word assembly, imm, redirects, wrap, async reset.
// Each call to run_period covers one 4-cycle period starting at ctr==0.
// Inputs change 1 unit after the rising edge; outputs are sampled 2 units later.
module tb_idli_fetch_m;

    logic        gck = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ctr;
    logic [15:0] enc;
    logic        enc_vld;
    logic [15:0] pc;
    logic        imm = 1'b0;
    logic        redir = 1'b0;
    logic [15:0] redir_pc = 16'h0000;
    logic        cs_n;
    logic        oe;
    logic [3:0]  sqi_out;
    logic [3:0]  sqi_in = 4'h0;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0]  p_cs;
    logic [3:0]  p_oe;
    logic [15:0] p_out;
    logic [7:0]  p_ctr;
    logic        p_vld;
    logic        p_extra;
    logic [15:0] p_enc;
    logic [15:0] p_pc;

    always #5 gck = ~gck;

    idli_fetch_m dut (
        .i_fe_gck      (gck),
        .i_fe_rst_n    (rst_n),
        .o_fe_ctr      (ctr),
        .o_fe_enc      (enc),
        .o_fe_enc_vld  (enc_vld),
        .o_fe_pc       (pc),
        .i_fe_imm      (imm),
        .i_fe_redir    (redir),
        .i_fe_redir_pc (redir_pc),
        .o_fe_sqi_cs_n (cs_n),
        .o_fe_sqi_oe   (oe),
        .o_fe_sqi_out  (sqi_out),
        .i_fe_sqi_in   (sqi_in)
    );

    // One period: nibble k of word fed at ctr==k, redirect asserted where rmask[k] is set.
    task automatic run_period(input logic [15:0] word, input logic im, input logic [3:0] rmask,
                              input logic [15:0] rpc);
        p_extra = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sqi_in   = word[4*k +: 4];
            imm      = im;
            redir    = rmask[k];
            redir_pc = rpc;
            #2;
            p_cs[k]          = cs_n;
            p_oe[k]          = oe;
            p_out[4*k +: 4]  = sqi_out;
            p_ctr[2*k +: 2]  = ctr;
            if (k == 3) begin
                p_vld = enc_vld;
                p_enc = enc;
                p_pc  = pc;
            end else if (enc_vld) begin
                p_extra = 1'b1;
            end
            @(posedge gck);
            #1;
        end
        imm   = 1'b0;
        redir = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (ctr !== 2'd0) begin miscompares++; $display("FAIL reset_ctr: got %0d want 0", ctr); end
        vectors++; if (cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        vectors++; if (oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe: got %b want 0", oe); end
        vectors++; if (sqi_out !== 4'h0) begin miscompares++; $display("FAIL reset_out: got %h want 0", sqi_out); end
        vectors++; if (enc_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld: got %b want 0", enc_vld); end
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc: got %h want 0000", pc); end
        @(posedge gck);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_setup_trace();
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_ctr !== 8'hE4) begin miscompares++; $display("FAIL ctr_seq: got %h want e4", p_ctr); end
        vectors++; if (p_cs !== 4'b0011) begin miscompares++; $display("FAIL p1_cs: got %b want 0011", p_cs); end
        vectors++; if (p_oe !== 4'b1100) begin miscompares++; $display("FAIL p1_oe: got %b want 1100", p_oe); end
        vectors++; if (p_out !== 16'h3000) begin miscompares++; $display("FAIL p1_cmd: got %h want 3000", p_out); end
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_cs !== 4'b0000) begin miscompares++; $display("FAIL p2_cs: got %b want 0000", p_cs); end
        vectors++; if (p_oe !== 4'b1111) begin miscompares++; $display("FAIL p2_oe: got %b want 1111", p_oe); end
        vectors++; if (p_out !== 16'h0000) begin miscompares++; $display("FAIL p2_addr: got %h want 0000", p_out); end
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_oe !== 4'b0011) begin miscompares++; $display("FAIL p3_oe: got %b want 0011", p_oe); end
        vectors++; if (p_out !== 16'h0000) begin miscompares++; $display("FAIL p3_addr: got %h want 0000", p_out); end
        vectors++; if (p_vld !== 1'b0) begin miscompares++; $display("FAIL p3_vld: got %b want 0", p_vld); end
    endtask

    task automatic test_first_word();
        run_period(16'h4321, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_vld !== 1'b1) begin miscompares++; $display("FAIL w0_vld: got %b want 1", p_vld); end
        vectors++; if (p_enc !== 16'h4321) begin miscompares++; $display("FAIL w0_enc: got %h want 4321", p_enc); end
        vectors++; if (p_pc !== 16'h0000) begin miscompares++; $display("FAIL w0_pc: got %h want 0000", p_pc); end
        vectors++; if (p_extra !== 1'b0) begin miscompares++; $display("FAIL w0_early_vld: got %b want 0", p_extra); end
        vectors++; if (p_cs !== 4'b0000) begin miscompares++; $display("FAIL w0_cs: got %b want 0000", p_cs); end
    endtask

    task automatic test_streaming();
        run_period(16'hBEEF, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_vld !== 1'b1) begin miscompares++; $display("FAIL w1_vld: got %b want 1", p_vld); end
        vectors++; if (p_enc !== 16'hBEEF) begin miscompares++; $display("FAIL w1_enc: got %h want beef", p_enc); end
        vectors++; if (p_pc !== 16'h0001) begin miscompares++; $display("FAIL w1_pc: got %h want 0001", p_pc); end
        run_period(16'h5A5A, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_enc !== 16'h5A5A) begin miscompares++; $display("FAIL w2_enc: got %h want 5a5a", p_enc); end
        vectors++; if (p_pc !== 16'h0002) begin miscompares++; $display("FAIL w2_pc: got %h want 0002", p_pc); end
    endtask

    task automatic test_immediate();
        run_period(16'hC0DE, 1'b1, 4'b0000, 16'h0000);
        vectors++; if (p_vld !== 1'b0) begin miscompares++; $display("FAIL imm_vld: got %b want 0", p_vld); end
        run_period(16'h1357, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_vld !== 1'b1) begin miscompares++; $display("FAIL post_imm_vld: got %b want 1", p_vld); end
        vectors++; if (p_pc !== 16'h0004) begin miscompares++; $display("FAIL post_imm_pc: got %h want 0004", p_pc); end
        vectors++; if (p_enc !== 16'h1357) begin miscompares++; $display("FAIL post_imm_enc: got %h want 1357", p_enc); end
    endtask

    task automatic test_redirect();
        run_period(16'hFFFF, 1'b1, 4'b1000, 16'h1234);
        vectors++; if (p_vld !== 1'b0) begin miscompares++; $display("FAIL redir_vld: got %b want 0", p_vld); end
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_cs !== 4'b0011) begin miscompares++; $display("FAIL redir_idle_cs: got %b want 0011", p_cs); end
        vectors++; if (p_out !== 16'h3000) begin miscompares++; $display("FAIL redir_cmd: got %h want 3000", p_out); end
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_out !== 16'h4200) begin miscompares++; $display("FAIL redir_addr0: got %h want 4200", p_out); end
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_out !== 16'h0086) begin miscompares++; $display("FAIL redir_addr1: got %h want 0086", p_out); end
        vectors++; if (p_oe !== 4'b0011) begin miscompares++; $display("FAIL redir_dummy_oe: got %b want 0011", p_oe); end
        // Redirect raised only at ctr 0..2 must be ignored.
        run_period(16'h7777, 1'b0, 4'b0111, 16'hDEAD);
        vectors++; if (p_vld !== 1'b1) begin miscompares++; $display("FAIL redir_w_vld: got %b want 1", p_vld); end
        vectors++; if (p_pc !== 16'h1234) begin miscompares++; $display("FAIL redir_w_pc: got %h want 1234", p_pc); end
        vectors++; if (p_enc !== 16'h7777) begin miscompares++; $display("FAIL redir_w_enc: got %h want 7777", p_enc); end
        run_period(16'h2468, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_pc !== 16'h1235) begin miscompares++; $display("FAIL redir_w2_pc: got %h want 1235", p_pc); end
    endtask

    task automatic test_redir_addr();
        run_period(16'h0000, 1'b0, 4'b1000, 16'h0100);
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        run_period(16'h0000, 1'b0, 4'b1000, 16'h0010);
        vectors++; if (p_out !== 16'h2000) begin miscompares++; $display("FAIL abort_addr0: got %h want 2000", p_out); end
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_cs !== 4'b0011) begin miscompares++; $display("FAIL abort_idle_cs: got %b want 0011", p_cs); end
        vectors++; if (p_out !== 16'h3000) begin miscompares++; $display("FAIL abort_cmd: got %h want 3000", p_out); end
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_out !== 16'h0000) begin miscompares++; $display("FAIL abort_addr0b: got %h want 0000", p_out); end
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_out !== 16'h0002) begin miscompares++; $display("FAIL abort_addr1: got %h want 0002", p_out); end
        run_period(16'hABCD, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_vld !== 1'b1) begin miscompares++; $display("FAIL abort_w_vld: got %b want 1", p_vld); end
        vectors++; if (p_pc !== 16'h0010) begin miscompares++; $display("FAIL abort_w_pc: got %h want 0010", p_pc); end
    endtask

    task automatic test_wrap();
        run_period(16'h0000, 1'b0, 4'b1000, 16'hFFFE);
        for (int i = 0; i < 3; i++) run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        run_period(16'h1111, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_pc !== 16'hFFFE) begin miscompares++; $display("FAIL wrap_fffe_pc: got %h want fffe", p_pc); end
        run_period(16'h2222, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_vld !== 1'b1) begin miscompares++; $display("FAIL wrap_ffff_vld: got %b want 1", p_vld); end
        vectors++; if (p_pc !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_ffff_pc: got %h want ffff", p_pc); end
        run_period(16'h3333, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_cs !== 4'b0011) begin miscompares++; $display("FAIL wrap_idle_cs: got %b want 0011", p_cs); end
        vectors++; if (p_vld !== 1'b0) begin miscompares++; $display("FAIL wrap_idle_vld: got %b want 0", p_vld); end
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_out !== 16'h0000) begin miscompares++; $display("FAIL wrap_addr0: got %h want 0000", p_out); end
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_out !== 16'h0000) begin miscompares++; $display("FAIL wrap_addr1: got %h want 0000", p_out); end
        run_period(16'h4444, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_vld !== 1'b1) begin miscompares++; $display("FAIL wrap_w_vld: got %b want 1", p_vld); end
        vectors++; if (p_pc !== 16'h0000) begin miscompares++; $display("FAIL wrap_w_pc: got %h want 0000", p_pc); end
        vectors++; if (p_enc !== 16'h4444) begin miscompares++; $display("FAIL wrap_w_enc: got %h want 4444", p_enc); end
    endtask

    task automatic test_async_reset();
        // Entering ctr==0 of a DATA period (pc 1); pull reset mid-cycle.
        sqi_in = 4'h5;
        #2;
        vectors++; if (cs_n !== 1'b0) begin miscompares++; $display("FAIL pre_rst_cs_n: got %b want 0", cs_n); end
        rst_n = 1'b0;
        #1;
        vectors++; if (cs_n !== 1'b1) begin miscompares++; $display("FAIL arst_cs_n: got %b want 1", cs_n); end
        vectors++; if (ctr !== 2'd0) begin miscompares++; $display("FAIL arst_ctr: got %0d want 0", ctr); end
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL arst_pc: got %h want 0000", pc); end
        @(posedge gck);
        #1;
        rst_n = 1'b1;
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_ctr !== 8'hE4) begin miscompares++; $display("FAIL rel_ctr_seq: got %h want e4", p_ctr); end
        vectors++; if (p_cs !== 4'b0011) begin miscompares++; $display("FAIL rel_cs: got %b want 0011", p_cs); end
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        run_period(16'h9876, 1'b0, 4'b0000, 16'h0000);
        vectors++; if (p_vld !== 1'b1) begin miscompares++; $display("FAIL rel_w_vld: got %b want 1", p_vld); end
        vectors++; if (p_enc !== 16'h9876) begin miscompares++; $display("FAIL rel_w_enc: got %h want 9876", p_enc); end
        vectors++; if (p_pc !== 16'h0000) begin miscompares++; $display("FAIL rel_w_pc: got %h want 0000", p_pc); end
    endtask

    initial begin
        test_reset();
        test_setup_trace();
        test_first_word();
        test_streaming();
        test_immediate();
        test_redirect();
        test_redir_addr();
        test_wrap();
        run_period(16'h0000, 1'b0, 4'b0000, 16'h0000);
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
